// File: rtl/game_flow_ctrl_pkg.sv
// Shared screen and task codes for the game sequencer and the UI overlay renderer.
// Helpers classify screens and give the last cursor index of each menu.
package game_flow_ctrl_pkg;

    typedef enum logic [3:0] {
        S_TITLE    = 4'd0,
        S_STAFF    = 4'd1,
        S_STAGE1   = 4'd2,
        S_SUCCESS1 = 4'd3,
        S_STAGE2   = 4'd4,
        S_SUCCESS2 = 4'd5,
        S_STAGE3   = 4'd6,
        S_SUCCESS3 = 4'd7,
        S_FAIL     = 4'd8,
        S_HELP     = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        TODO_NONE       = 2'd0,
        TODO_FIND_KEY   = 2'd1,
        TODO_FIND_LIGHT = 2'd2,
        TODO_FIND_DOOR  = 2'd3
    } todo_t;

    localparam logic [3:0] PLAY_VALID_RST = 4'b0010;

    function automatic logic is_stage(input state_t s);
        return (s == S_STAGE1) || (s == S_STAGE2) || (s == S_STAGE3);
    endfunction

    // Highest selectable cursor index; single-item screens return 0.
    function automatic logic [1:0] menu_last(input state_t s);
        case (s)
            S_TITLE:                          return 2'd3;
            S_SUCCESS1, S_SUCCESS2, S_FAIL:   return 2'd1;
            default:                          return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bus between the game sequencer, the input/event sources and the overlay renderer.
// Optional time_left exists only when STAGE_TIMER_EN is defined.
interface game_flow_ctrl_if;
    // Every input is a one-cycle pulse with no back-pressure: it is consumed on the
    // next rising edge and must be low again afterwards. Outputs are registered levels.
    logic       btn_up;
    logic       btn_down;
    logic       btn_enter;
    logic       key_got;
    logic       light_on;
    logic       door_reached;
    logic       hit;
    logic [3:0] state;
    logic [1:0] menu_sel;
    logic [1:0] key_find;
    logic [1:0] life;
    logic [1:0] todo;
    logic [3:0] play_valid;
`ifdef STAGE_TIMER_EN
    logic [6:0] time_left;
`endif

    modport slave (
        input  btn_up, btn_down, btn_enter, key_got, light_on, door_reached, hit,
        output state, menu_sel, key_find, life, todo, play_valid
`ifdef STAGE_TIMER_EN
        , output time_left
`endif
    );

    modport master (
        output btn_up, btn_down, btn_enter, key_got, light_on, door_reached, hit,
        input  state, menu_sel, key_find, life, todo, play_valid
`ifdef STAGE_TIMER_EN
        , input time_left
`endif
    );
endinterface

// File: rtl/game_flow_ctrl_stage_timer.sv
// Per-stage countdown: a CLK_HZ prescaler feeding a seconds down-counter.
// Only instantiated when STAGE_TIMER_EN is defined.
module stage_timer #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TIME_SEC = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       run,
    output logic       expired,
    output logic [6:0] time_left
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [PW-1:0] presc;
    logic [6:0]    secs;
    logic          tick;

    assign tick      = run && (presc == PW'(CLK_HZ - 1));
    assign time_left = secs;
    // Flag on the very tick that reaches zero so the sequencer leaves on that edge.
    assign expired   = run && ((secs == 7'd0) || (tick && secs == 7'd1));

    always_ff @(posedge clk) begin
        if (rst || load) begin
            presc <= '0;
            secs  <= 7'(TIME_SEC);
        end else if (run) begin
            if (tick) begin
                presc <= '0;
                if (secs != 7'd0) secs <= secs - 7'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end
endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: screens, menu cursor, stage tasks, lives and unlocks.
// Optional per-stage time limit is enabled by defining STAGE_TIMER_EN.
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int KEYS_REQ  = 3,
    parameter int LIFE_INIT = 3
`ifdef STAGE_TIMER_EN
    , parameter int CLK_HZ   = 100_000_000
    , parameter int TIME_SEC = 60
`endif
) (
    input  logic             clk,
    input  logic             rst,
    game_flow_ctrl_if.slave  bus
);
    localparam logic [1:0] KEYS_W = 2'(KEYS_REQ);
    localparam logic [1:0] LIFE_W = 2'(LIFE_INIT);

    state_t     state_q, state_d, last_q, last_d, enter_stage;
    todo_t      todo_q, todo_d;
    logic [1:0] menu_q, menu_d, menu_move, menu_max;
    logic [1:0] key_q, key_d;
    logic [1:0] life_q, life_d;
    logic [3:0] pv_q, pv_d;
    logic       enter_req;
    logic       in_stage;
    logic       legal;
    logic       timer_expired;

`ifdef STAGE_TIMER_EN
    stage_timer #(
        .CLK_HZ   (CLK_HZ),
        .TIME_SEC (TIME_SEC)
    ) u_stage_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (enter_req),
        .run       (in_stage),
        .expired   (timer_expired),
        .time_left (bus.time_left)
    );
`else
    assign timer_expired = 1'b0;
`endif

    assign in_stage = is_stage(state_q);
    assign legal    = (state_q <= S_HELP);
    assign menu_max = menu_last(state_q);

    always_comb begin
        menu_move = menu_q;
        if (bus.btn_up && !bus.btn_down)
            menu_move = (menu_q == 2'd0) ? menu_max : menu_q - 2'd1;
        else if (bus.btn_down && !bus.btn_up)
            menu_move = (menu_q == menu_max) ? 2'd0 : menu_q + 2'd1;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        todo_d      = todo_q;
        menu_d      = menu_q;
        key_d       = key_q;
        life_d      = life_q;
        pv_d        = pv_q;
        enter_req   = 1'b0;
        enter_stage = S_STAGE1;

        case (state_q)
            S_TITLE: if (bus.btn_enter) begin
                case (menu_q)
                    2'd0: begin enter_req = 1'b1; enter_stage = S_STAGE1; end
                    2'd1: if (pv_q[2]) begin enter_req = 1'b1; enter_stage = S_STAGE2; end
                    2'd2: if (pv_q[3]) begin enter_req = 1'b1; enter_stage = S_STAGE3; end
                    default: state_d = S_HELP;
                endcase
            end
            S_STAFF, S_HELP: if (bus.btn_enter) state_d = S_TITLE;
            S_SUCCESS1: if (bus.btn_enter) begin
                if (menu_q == 2'd0) begin enter_req = 1'b1; enter_stage = S_STAGE2; end
                else state_d = S_TITLE;
            end
            S_SUCCESS2: if (bus.btn_enter) begin
                if (menu_q == 2'd0) begin enter_req = 1'b1; enter_stage = S_STAGE3; end
                else state_d = S_TITLE;
            end
            S_SUCCESS3: if (bus.btn_enter) state_d = S_STAFF;
            S_FAIL: if (bus.btn_enter) begin
                if (menu_q == 2'd0) begin enter_req = 1'b1; enter_stage = last_q; end
                else state_d = S_TITLE;
            end
            S_STAGE1, S_STAGE2, S_STAGE3: begin
                // Only the highest-priority pulse acts, even if its condition then fails.
                if (bus.hit && state_q == S_STAGE3) begin
                    if (life_q <= 2'd1) begin
                        state_d = S_FAIL;
                        life_d  = 2'd0;
                    end else begin
                        life_d = life_q - 2'd1;
                    end
                end else if (timer_expired) begin
                    state_d = S_FAIL;
                end else if (bus.door_reached) begin
                    if (todo_q == TODO_FIND_DOOR) begin
                        case (state_q)
                            S_STAGE1: begin state_d = S_SUCCESS1; pv_d[2] = 1'b1; end
                            S_STAGE2: begin state_d = S_SUCCESS2; pv_d[3] = 1'b1; end
                            default:  state_d = S_SUCCESS3;
                        endcase
                    end
                end else if (bus.key_got) begin
                    if (todo_q == TODO_FIND_KEY && key_q < KEYS_W) begin
                        key_d = key_q + 2'd1;
                        if (key_q + 2'd1 == KEYS_W) todo_d = TODO_FIND_DOOR;
                    end
                end else if (bus.light_on) begin
                    if (todo_q == TODO_FIND_LIGHT) todo_d = TODO_FIND_KEY;
                end
            end
            default: state_d = S_TITLE;
        endcase

        if (legal && !in_stage && !bus.btn_enter)
            menu_d = menu_move;

        if (enter_req) begin
            state_d = enter_stage;
            last_d  = enter_stage;
            key_d   = 2'd0;
            life_d  = LIFE_W;
            todo_d  = (enter_stage == S_STAGE2) ? TODO_FIND_LIGHT : TODO_FIND_KEY;
        end else if (!is_stage(state_d)) begin
            todo_d = TODO_NONE;
        end

        if (state_d != state_q)
            menu_d = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_TITLE;
            last_q  <= S_STAGE1;
            todo_q  <= TODO_NONE;
            menu_q  <= 2'd0;
            key_q   <= 2'd0;
            life_q  <= LIFE_W;
            pv_q    <= PLAY_VALID_RST;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            todo_q  <= todo_d;
            menu_q  <= menu_d;
            key_q   <= key_d;
            life_q  <= life_d;
            pv_q    <= pv_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.menu_sel   = menu_q;
    assign bus.key_find   = key_q;
    assign bus.life       = life_q;
    assign bus.todo       = todo_q;
    assign bus.play_valid = pv_q;
endmodule
